// File: rtl/ila_trace_pkg.sv
// Shared types and widths for the hart trace mux.
// Record layout, field widths, hart-id width helper.
package ila_trace_pkg;

  localparam int PC_W_D     = 40;
  localparam int XLEN_D     = 64;
  localparam int TS_W_D     = 32;
  localparam int INSTR_W    = 32;
  localparam int RADDR_W    = 5;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [TS_W_D-1:0]  ts;
    logic [XLEN_D-1:0]  rd_wdata;
    logic [RADDR_W-1:0] rd_waddr;
    logic               rd_wen;
    logic [INSTR_W-1:0] instr;
    logic [PC_W_D-1:0]  pc;
  } ila_rec_t;

  function automatic int hart_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rec_w(
    input int pc_w,
    input int xlen,
    input int ts_w
  );
    return ts_w + xlen + RADDR_W + 1 + INSTR_W + pc_w;
  endfunction

endpackage

// File: rtl/ila_trace_fifo.sv
// Per-hart synchronous record FIFO, DEPTH entries (power of two).
// Ports: clk, rst_n, push, pop, wdata, rdata, full, empty.
module ila_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot the push lands in,
  // so a full FIFO still takes a push that cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ila_trace_mux.sv
// Serialises per-hart commit traces onto one valid/ready stream.
// Per-hart FIFOs, round-robin drain, drop counters, registered output.
// Ports: uncoreclk, uncorerst_n, enable, clear, in_* (hart-sliced),
//   out_valid/out_ready, out_hartid, out_* record, drop_cnt, overflow.
// Option: ILA_TRACE_TS_EN adds a capture timestamp driven on out_time.
module ila_trace_mux
  import ila_trace_pkg::*;
#(
  parameter int NHARTS = 2,
  parameter int DEPTH  = 8,
  parameter int PC_W   = PC_W_D,
  parameter int XLEN   = XLEN_D,
  parameter int TS_W   = TS_W_D,
  localparam int HART_W = hart_w(NHARTS)
) (
  input  logic                         uncoreclk,
  input  logic                         uncorerst_n,
  input  logic [NHARTS-1:0]            enable,
  input  logic                         clear,
  input  logic [NHARTS-1:0]            in_valid,
  input  logic [NHARTS*PC_W-1:0]       in_pc,
  input  logic [NHARTS*INSTR_W-1:0]    in_instr,
  input  logic [NHARTS-1:0]            in_rd_wen,
  input  logic [NHARTS*RADDR_W-1:0]    in_rd_waddr,
  input  logic [NHARTS*XLEN-1:0]       in_rd_wdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [HART_W-1:0]            out_hartid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  output logic                         out_rd_wen,
  output logic [RADDR_W-1:0]           out_rd_waddr,
  output logic [XLEN-1:0]              out_rd_wdata,
  output logic [TS_W-1:0]              out_time,
  output logic [NHARTS*DROP_CNT_W-1:0] drop_cnt,
  output logic [NHARTS-1:0]            overflow
);

`ifdef ILA_TRACE_TS_EN
  localparam int REC_W = rec_w(PC_W, XLEN, TS_W);
`else
  localparam int REC_W = rec_w(PC_W, XLEN, 0);
`endif

  logic [NHARTS-1:0] cap;
  logic [NHARTS-1:0] pop;
  logic [NHARTS-1:0] full;
  logic [NHARTS-1:0] empty;
  logic [NHARTS-1:0] drop;
  logic [REC_W-1:0]  wrec [NHARTS];
  logic [REC_W-1:0]  rrec [NHARTS];
  logic [REC_W-1:0]  sel;
  logic [HART_W-1:0] ptr;
  logic [HART_W-1:0] ptr_nxt;
  logic [HART_W-1:0] grant;
  logic              found;
  logic              load;

`ifdef ILA_TRACE_TS_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] out_time_q;

  always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
    if (!uncorerst_n) ts <= '0;
    else              ts <= ts + 1'b1;
  end

  assign out_time = out_time_q;
`else
  assign out_time = '0;
`endif

  assign cap  = in_valid & enable;
  assign drop = cap & full & ~pop;

  for (genvar i = 0; i < NHARTS; i++) begin : g_hart
    logic [DROP_CNT_W-1:0] cnt_q;
    logic                  ovf_q;

    assign wrec[i] = {
`ifdef ILA_TRACE_TS_EN
      ts,
`endif
      in_rd_wdata[i*XLEN +: XLEN],
      in_rd_waddr[i*RADDR_W +: RADDR_W],
      in_rd_wen[i],
      in_instr[i*INSTR_W +: INSTR_W],
      in_pc[i*PC_W +: PC_W]
    };

    ila_trace_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (uncoreclk),
      .rst_n (uncorerst_n),
      .push  (cap[i]),
      .pop   (pop[i]),
      .wdata (wrec[i]),
      .rdata (rrec[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    // clear outranks a same-cycle drop
    always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
      if (!uncorerst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (drop[i]) begin
        ovf_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end

    assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = cnt_q;
    assign overflow[i] = ovf_q;
  end

  // Round-robin: harts at/above ptr first, then wrap below it.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int j = 0; j < NHARTS; j++) begin
      if (!found && !empty[j] && j >= int'(ptr)) begin
        found = 1'b1;
        grant = HART_W'(j);
      end
    end
    for (int j = 0; j < NHARTS; j++) begin
      if (!found && !empty[j] && j < int'(ptr)) begin
        found = 1'b1;
        grant = HART_W'(j);
      end
    end
  end

  assign load    = ~out_valid | out_ready;
  assign sel     = rrec[grant];
  assign ptr_nxt = (int'(grant) == NHARTS - 1) ?
                   '0 : grant + 1'b1;

  always_comb begin
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
  end

  always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
    if (!uncorerst_n) begin
      out_valid    <= 1'b0;
      out_hartid   <= '0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_rd_wen   <= 1'b0;
      out_rd_waddr <= '0;
      out_rd_wdata <= '0;
`ifdef ILA_TRACE_TS_EN
      out_time_q   <= '0;
`endif
      ptr          <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_hartid <= grant;
        ptr        <= ptr_nxt;
        {
`ifdef ILA_TRACE_TS_EN
          out_time_q,
`endif
          out_rd_wdata,
          out_rd_waddr,
          out_rd_wen,
          out_instr,
          out_pc
        } <= sel;
      end
    end
  end

endmodule

// File: tb/tb_ila_trace_mux.sv
// Directed bench for ila_trace_mux: vector table plus
// hand sequences for overflow, full push/pop, hold, clear, reset.
module tb_ila_trace_mux;
  import ila_trace_pkg::*;

  localparam int N  = 2;
  localparam int D  = 8;
  localparam int PW = 40;
  localparam int XL = 64;
  localparam int TW = 32;

`ifdef ILA_TRACE_TS_EN
  localparam logic [TW-1:0] TS_A = 32'd4;
  localparam logic [TW-1:0] TS_B = 32'd5;
`else
  localparam logic [TW-1:0] TS_A = 32'd0;
  localparam logic [TW-1:0] TS_B = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    enable;
  logic            clear;
  logic [N-1:0]    in_valid;
  logic [N*PW-1:0] in_pc;
  logic [N*32-1:0] in_instr;
  logic [N-1:0]    in_rd_wen;
  logic [N*5-1:0]  in_rd_waddr;
  logic [N*XL-1:0] in_rd_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [0:0]      out_hartid;
  logic [PW-1:0]   out_pc;
  logic [31:0]     out_instr;
  logic            out_rd_wen;
  logic [4:0]      out_rd_waddr;
  logic [XL-1:0]   out_rd_wdata;
  logic [TW-1:0]   out_time;
  logic [N*16-1:0] drop_cnt;
  logic [N-1:0]    overflow;

  ila_trace_mux #(
    .NHARTS (N),
    .DEPTH  (D),
    .PC_W   (PW),
    .XLEN   (XL),
    .TS_W   (TW)
  ) dut (
    .uncoreclk    (clk),
    .uncorerst_n  (rst_n),
    .enable       (enable),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_rd_wen    (in_rd_wen),
    .in_rd_waddr  (in_rd_waddr),
    .in_rd_wdata  (in_rd_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hartid   (out_hartid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_rd_wen   (out_rd_wen),
    .out_rd_waddr (out_rd_waddr),
    .out_rd_wdata (out_rd_wdata),
    .out_time     (out_time),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] f_instr(input logic [39:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction
  function automatic logic f_wen(input logic [39:0] pc);
    return pc[2];
  endfunction
  function automatic logic [4:0] f_waddr(input logic [39:0] pc);
    return pc[6:2];
  endfunction
  function automatic logic [63:0] f_wdata(input logic [39:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_rec(
    input string       nm,
    input logic        h,
    input logic [39:0] pc
  );
    ila_rec_t e;
    e          = '0;
    e.pc       = pc;
    e.instr    = f_instr(pc);
    e.rd_wen   = f_wen(pc);
    e.rd_waddr = f_waddr(pc);
    e.rd_wdata = f_wdata(pc);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_hartid"}, out_hartid, h);
    chk({nm, "_pc"}, out_pc, e.pc);
    chk({nm, "_fields"},
        {out_rd_wdata, out_rd_waddr, out_rd_wen, out_instr},
        {e.rd_wdata, e.rd_waddr, e.rd_wen, e.instr});
  endtask

  task automatic drive(
    input logic [1:0]  v,
    input logic [39:0] p0,
    input logic [39:0] p1
  );
    in_valid    = v;
    in_pc       = {p1, p0};
    in_instr    = {f_instr(p1), f_instr(p0)};
    in_rd_wen   = {f_wen(p1), f_wen(p0)};
    in_rd_waddr = {f_waddr(p1), f_waddr(p0)};
    in_rd_wdata = {f_wdata(p1), f_wdata(p0)};
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    enable    = 2'b11;
    clear     = 1'b0;
    drive(2'b00, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic [39:0] pc0;
    logic [39:0] pc1;
    logic        ev;
    logic        eh;
    logic [39:0] epc;
  } vec_t;

  vec_t tv [16];

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{2'b01, 1'b1, 40'h8000_0000, 40'h0, 1'b0, 1'b0, 40'h0};
    tv[1]  = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b0, 40'h8000_0000};
    tv[2]  = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b0, 1'b0, 40'h0};
    tv[3]  = '{2'b10, 1'b1, 40'h0, 40'h9000_0000, 1'b0, 1'b0, 40'h0};
    tv[4]  = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b1, 40'h9000_0000};
    tv[5]  = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b0, 1'b0, 40'h0};
    tv[6]  = '{2'b11, 1'b1, 40'h100, 40'h200, 1'b0, 1'b0, 40'h0};
    tv[7]  = '{2'b11, 1'b1, 40'h104, 40'h204, 1'b1, 1'b0, 40'h100};
    tv[8]  = '{2'b11, 1'b1, 40'h108, 40'h208, 1'b1, 1'b1, 40'h200};
    tv[9]  = '{2'b11, 1'b1, 40'h10c, 40'h20c, 1'b1, 1'b0, 40'h104};
    tv[10] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b1, 40'h204};
    tv[11] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b0, 40'h108};
    tv[12] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b1, 40'h208};
    tv[13] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b0, 40'h10c};
    tv[14] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b1, 1'b1, 40'h20c};
    tv[15] = '{2'b00, 1'b1, 40'h0, 40'h0, 1'b0, 1'b0, 40'h0};

    rst_n     = 1'b1;
    out_ready = 1'b0;
    enable    = 2'b11;
    clear     = 1'b0;
    drive(2'b00, '0, '0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_fields",
        {out_hartid, out_pc, out_instr, out_rd_wen,
         out_rd_waddr, out_rd_wdata, out_time},
        '0);
    chk("rst_drop", drop_cnt, 32'h0);
    chk("rst_ovf", overflow, 2'b00);
    rst_n = 1'b1;

    // single records, then both harts streaming
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].v, tv[i].pc0, tv[i].pc1);
      out_ready = tv[i].rdy;
      @(negedge clk);
      if (tv[i].ev) check_rec("tv", tv[i].eh, tv[i].epc);
      else chk("tv_valid", out_valid, 1'b0);
      chk("tv_drop", {drop_cnt, overflow}, 34'h0);
    end

    // overflow: hart1 pushes DEPTH+4 with sink stalled
    do_reset();
    for (int k = 0; k < D + 4; k++) begin
      drive(2'b10, '0, 40'h3000 + 40'(4 * k));
      @(negedge clk);
    end
    drive(2'b00, '0, '0);
    chk("ovf_cnt", drop_cnt, {16'd3, 16'd0});
    chk("ovf_flag", overflow, 2'b10);
    out_ready = 1'b1;
    for (int j = 0; j <= D; j++) begin
      check_rec("ovf_drain", 1'b1, 40'h3000 + 40'(4 * j));
      @(negedge clk);
    end
    chk("ovf_empty", out_valid, 1'b0);

    // full FIFO: push and pop on the same edge
    do_reset();
    for (int k = 0; k <= D; k++) begin
      drive(2'b01, 40'h4000 + 40'(4 * k), '0);
      @(negedge clk);
    end
    chk("full_nodrop", {drop_cnt, overflow}, 34'h0);
    drive(2'b01, 40'h4000 + 40'(4 * (D + 1)), '0);
    out_ready = 1'b1;
    @(negedge clk);
    drive(2'b00, '0, '0);
    chk("pp_nodrop", {drop_cnt, overflow}, 34'h0);
    for (int j = 1; j <= D + 1; j++) begin
      check_rec("pp_drain", 1'b0, 40'h4000 + 40'(4 * j));
      @(negedge clk);
    end
    chk("pp_empty", out_valid, 1'b0);

    // hold under stall, enable-low, clear vs drop
    do_reset();
    for (int k = 0; k < D + 3; k++) begin
      drive(2'b01, 40'h5000 + 40'(4 * k), '0);
      @(negedge clk);
    end
    chk("hold_cnt", drop_cnt, {16'd0, 16'd2});
    enable = 2'b00;
    drive(2'b01, 40'h5100, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_rec("hold", 1'b0, 40'h5000);
      chk("hold_en_drop", drop_cnt, {16'd0, 16'd2});
    end
    enable = 2'b11;
    drive(2'b01, 40'h5200, '0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_cnt", drop_cnt, 32'h0);
    chk("clr_ovf", overflow, 2'b00);
    check_rec("clr_hold", 1'b0, 40'h5000);
    drive(2'b01, 40'h5204, '0);
    @(negedge clk);
    drive(2'b00, '0, '0);
    chk("post_clr", {drop_cnt, overflow},
        {16'd0, 16'd1, 2'b01});

    // async reset with records queued
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_pc", out_pc, 40'h0);
    chk("arst_cnt", {drop_cnt, overflow}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("arst_idle", out_valid, 1'b0);
    end
    drive(2'b01, 40'h6000, '0);
    @(negedge clk);
    drive(2'b01, 40'h6004, '0);
    @(negedge clk);
    drive(2'b00, '0, '0);
    check_rec("ts_a", 1'b0, 40'h6000);
    chk("ts_a_time", out_time, TS_A);
    @(negedge clk);
    check_rec("ts_b", 1'b0, 40'h6004);
    chk("ts_b_time", out_time, TS_B);
    @(negedge clk);
    chk("ts_end", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
